// File: rtl/bcd_display_pkg.sv
// Shared constants for the BCD counter display.
// Segment codes are active-low: bit 7 = dp, bits 6..0 = g..a.
package bcd_display_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_encode(
    input logic [3:0] d
  );
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw button -> 2-flop sync -> debounce -> one-cycle press pulse.
// Release edges produce no pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic sysclock,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          clean;
  logic          clean_d;
  logic [CW-1:0] stab_cnt;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has been stable long enough.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      clean    <= 1'b0;
      stab_cnt <= '0;
    end else if (sync2 == clean) begin
      stab_cnt <= '0;
    end else if (stab_cnt == TERM) begin
      clean    <= ~clean;
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + CW'(1);
    end
  end

  // Delayed clean level for rising-edge detection.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) clean_d <= 1'b0;
    else       clean_d <= clean;
  end

  assign press = clean & ~clean_d;

endmodule

// File: rtl/bcd_counter_display.sv
// Up/down BCD counter driven by two buttons, shown on a
// multiplexed active-low seven-segment display.
module bcd_counter_display
  import bcd_display_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int SCAN_DIV        = 50000,
  parameter int BLANK_LZ        = 1
) (
  input  logic                    sysclock,
  input  logic                    reset,
  input  logic                    btn_inc_raw,
  input  logic                    btn_dec_raw,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap,
  output logic [NUM_DIGITS-1:0]   selector,
  output logic [7:0]              seg
);

  localparam int CNT_W = 4 * NUM_DIGITS;
  localparam int PW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_TERM = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_RST =
    ~(NUM_DIGITS'(1));

  logic             inc_p;
  logic             dec_p;
  logic [CNT_W-1:0] count_nxt;
  logic             wrap_nxt;
  logic             carry;
  logic [3:0]       dig;
  logic [PW-1:0]    presc;
  logic [IW-1:0]    idx;
  logic [3:0]       cur;
  logic             cur_blank;
  logic             zero_above;
  logic [7:0]       seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_inc (
    .sysclock(sysclock),
    .reset   (reset),
    .btn_raw (btn_inc_raw),
    .press   (inc_p)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dec (
    .sysclock(sysclock),
    .reset   (reset),
    .btn_raw (btn_dec_raw),
    .press   (dec_p)
  );

  // Decimal inc/dec with ripple carry/borrow; both at once is a no-op.
  always_comb begin
    count_nxt = count_bcd;
    wrap_nxt  = 1'b0;
    carry     = 1'b1;
    dig       = '0;
    if (inc_p && !dec_p) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig = count_bcd[4*i +: 4];
        if (carry) begin
          if (dig >= 4'd9) begin
            count_nxt[4*i +: 4] = 4'd0;
          end else begin
            count_nxt[4*i +: 4] = dig + 4'd1;
            carry = 1'b0;
          end
        end
      end
      wrap_nxt = carry;
    end else if (dec_p && !inc_p) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig = count_bcd[4*i +: 4];
        if (carry) begin
          if (dig == 4'd0) begin
            count_nxt[4*i +: 4] = 4'd9;
          end else begin
            count_nxt[4*i +: 4] = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
      wrap_nxt = carry;
    end
  end

  // Count and wrap pulse register together.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      count_bcd <= '0;
      wrap      <= 1'b0;
    end else begin
      count_bcd <= count_nxt;
      wrap      <= wrap_nxt;
    end
  end

  // Scan prescaler and digit index.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == P_TERM) begin
      presc <= '0;
      idx   <= (idx == I_LAST) ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Pick the scanned digit and decide leading-zero blanking.
  always_comb begin
    zero_above = 1'b1;
    cur        = '0;
    cur_blank  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above &
        (count_bcd[4*i +: 4] == 4'd0);
      if (idx == IW'(i)) begin
        cur       = count_bcd[4*i +: 4];
        cur_blank = (BLANK_LZ != 0) && (i != 0) &&
                    zero_above;
      end
    end
    seg_nxt = cur_blank ? SEG_BLANK : seg_encode(cur);
    sel_nxt = ~(NUM_DIGITS'(1) << idx);
  end

  // Selector and segments share one register stage.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      selector <= SEL_RST;
      seg      <= SEG_0;
    end else begin
      selector <= sel_nxt;
      seg      <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench for bcd_counter_display with a count scoreboard.
// Small parameters keep debounce and scan short.
module tb_bcd_counter_display;

  localparam int ND = 4;
  localparam int DC = 4;
  localparam int SD = 2;

  logic          sysclock = 1'b0;
  logic          reset;
  logic          btn_inc_raw;
  logic          btn_dec_raw;
  logic [15:0]   count_bcd;
  logic          wrap;
  logic [3:0]    selector;
  logic [7:0]    seg;

  typedef struct {
    logic [15:0] cnt;
    logic        wr;
  } exp_t;

  exp_t        sb[$];
  int          n_eval = 0;
  int          n_fail = 0;
  int          model  = 0;
  logic [15:0] prev_cnt;

  bcd_counter_display #(
    .NUM_DIGITS     (ND),
    .DEBOUNCE_CYCLES(DC),
    .SCAN_DIV       (SD),
    .BLANK_LZ       (1)
  ) dut (
    .sysclock   (sysclock),
    .reset      (reset),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .count_bcd  (count_bcd),
    .wrap       (wrap),
    .selector   (selector),
    .seg        (seg)
  );

  always #5 sysclock = ~sysclock;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Every count change must match the oldest expected entry.
  always @(negedge sysclock) begin
    if (reset) begin
      prev_cnt <= count_bcd;
    end else if (count_bcd !== prev_cnt) begin
      if (sb.size() == 0) begin
        check("unexpected_step", count_bcd, prev_cnt);
      end else begin
        check("count", count_bcd, sb[0].cnt);
        check("wrap", wrap, sb[0].wr);
        void'(sb.pop_front());
      end
      prev_cnt <= count_bcd;
    end else begin
      check("wrap_idle", wrap, 1'b0);
    end
  end

  task automatic press(input bit inc, input bit dec);
    for (int i = 0; i < 3; i++) begin
      @(posedge sysclock); #1;
      btn_inc_raw = inc & (i % 2 == 0);
      btn_dec_raw = dec & (i % 2 == 0);
    end
    repeat (10) @(posedge sysclock);
    for (int i = 0; i < 3; i++) begin
      @(posedge sysclock); #1;
      btn_inc_raw = inc & (i % 2 == 1);
      btn_dec_raw = dec & (i % 2 == 1);
    end
    repeat (12) @(posedge sysclock);
    #1;
  endtask

  task automatic step_inc();
    model = (model + 1) % 10000;
    sb.push_back('{cnt: to_bcd(model), wr: (model == 0)});
    press(1'b1, 1'b0);
    check("inc_drained", sb.size(), 0);
  endtask

  task automatic step_dec();
    model = (model + 9999) % 10000;
    sb.push_back('{cnt: to_bcd(model), wr: (model == 9999)});
    press(1'b0, 1'b1);
    check("dec_drained", sb.size(), 0);
  endtask

  task automatic scan_check(input logic [31:0] segs);
    int t;
    logic [3:0] es;
    t = 0;
    @(negedge sysclock);
    while (selector !== 4'b0111 && t < 40) begin
      @(negedge sysclock);
      t++;
    end
    while (selector !== 4'b1110 && t < 40) begin
      @(negedge sysclock);
      t++;
    end
    check("scan_sync", (t < 40), 1'b1);
    for (int k = 0; k < 8; k++) begin
      es = ~(4'b0001 << (k / 2));
      check("selector", selector, es);
      check("seg", seg, segs[8*(k/2) +: 8]);
      @(negedge sysclock);
    end
  endtask

  initial begin
    int t;
    reset       = 1'b1;
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    #2;
    check("rst_count", count_bcd, 16'h0000);
    check("rst_wrap", wrap, 1'b0);
    check("rst_sel", selector, 4'b1110);
    check("rst_seg", seg, 8'hC0);
    repeat (3) @(posedge sysclock);
    #2 reset = 1'b0;

    step_inc();
    check("c0001", count_bcd, 16'h0001);
    repeat (8) step_inc();
    check("c0009", count_bcd, 16'h0009);
    step_inc();
    check("c0010", count_bcd, 16'h0010);
    repeat (90) step_inc();
    check("c0100", count_bcd, 16'h0100);
    step_dec();
    check("c0099", count_bcd, 16'h0099);
    repeat (57) step_dec();
    check("c0042", count_bcd, 16'h0042);

    press(1'b1, 1'b1);
    check("both_count", count_bcd, 16'h0042);
    check("both_wrap", wrap, 1'b0);

    @(posedge sysclock); #2 reset = 1'b1;
    @(posedge sysclock); #2 reset = 1'b0;
    model = 0;
    check("re_count", count_bcd, 16'h0000);
    step_dec();
    check("c9999", count_bcd, 16'h9999);
    step_inc();
    check("c0000", count_bcd, 16'h0000);
    repeat (7) step_inc();
    check("c0007", count_bcd, 16'h0007);
    scan_check({8'hFF, 8'hFF, 8'hFF, 8'hF8});

    repeat (116) step_inc();
    check("c0123", count_bcd, 16'h0123);
    scan_check({8'hFF, 8'hF9, 8'hA4, 8'hB0});

    @(posedge sysclock); #1 btn_inc_raw = 1'b1;
    repeat (2) @(posedge sysclock);
    #3 reset = 1'b1;
    #1;
    check("mid_count", count_bcd, 16'h0000);
    check("mid_sel", selector, 4'b1110);
    check("mid_seg", seg, 8'hC0);
    check("mid_wrap", wrap, 1'b0);
    repeat (3) @(posedge sysclock);
    #2 reset = 1'b0;
    model = 1;
    sb.push_back('{cnt: to_bcd(1), wr: 1'b0});
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclock);
      check("hold_off", count_bcd, 16'h0000);
    end
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge sysclock);
      t++;
    end
    check("post_rst_press", sb.size(), 0);
    btn_inc_raw = 1'b0;
    repeat (12) @(posedge sysclock);
    #1;
    check("final_count", count_bcd, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end

endmodule
